// File: rtl/pal_sweep_checker.sv
// -----------------------------------------------------------------------------
// pal_sweep_checker
//
// Self-test sequencer for a 4-input / 4-output combinational PAL. It drives
// the PAL inputs {A,B,C,D} through all 16 combinations. For each vector it
// waits SETTLE_CYCLES cycles, then samples the PAL outputs {F4,F3,F2,F1}.
// Each sample is stored as one nibble of a 64-bit truth table and compared
// against the golden table EXPECTED.
//
// Parameters:
//   SETTLE_CYCLES  cycles abcd is held before the sample cycle (1..255;
//                  at least 2 when PAL_SWEEP_SYNC_EN is defined)
//   EXPECTED       golden table; nibble i = required {F4,F3,F2,F1} for index i
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   begin a sweep (accepted only in IDLE)
//   abcd       out  4   registered PAL inputs {A,B,C,D}, A = MSB
//   f_in       in   4   PAL outputs {F4,F3,F2,F1}
//   busy       out  1   sweep in progress
//   done       out  1   one-cycle pulse at the end of a sweep
//   pass       out  1   all 16 entries matched (valid from done until next start)
//   fail_idx   out  4   lowest mismatching index (0 when pass)
//   fail_cnt   out  5   number of mismatching indices, 0..16
//   table_out  out  64  captured truth table, same layout as EXPECTED
//
// Optional feature:
//   PAL_SWEEP_SYNC_EN  when defined, f_in passes through a two-flop
//                      synchronizer before capture and compare. Use this when
//                      the PAL sits on another device or board. The sweep
//                      length does not change.
// -----------------------------------------------------------------------------
module pal_sweep_checker #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [63:0] EXPECTED      = 64'hFEDCBA9876543210
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic [3:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_idx,
    output logic [4:0]  fail_cnt,
    output logic [63:0] table_out
);

    // Elaboration-time legality checks on the settle time.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("pal_sweep_checker: SETTLE_CYCLES must be in 1..255");
        end
`ifdef PAL_SWEEP_SYNC_EN
        // The synchronizer adds two edges of delay. The sample must still
        // see the current abcd, so at least two settle cycles are needed.
        if (SETTLE_CYCLES < 2) begin : g_bad_sync_settle
            $error("pal_sweep_checker: SETTLE_CYCLES must be >= 2 with PAL_SWEEP_SYNC_EN");
        end
`endif
    endgenerate

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  abcd_q, abcd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [3:0]  fail_idx_q, fail_idx_d;
    logic [4:0]  fail_cnt_q, fail_cnt_d;
    logic [63:0] table_q, table_d;

    // PAL response as seen by the compare / capture logic.
    logic [3:0]  f_cmp;

`ifdef PAL_SWEEP_SYNC_EN
    logic [3:0] f_sync1_q, f_sync1_d;
    logic [3:0] f_sync2_q, f_sync2_d;

    assign f_sync1_d = f_in;
    assign f_sync2_d = f_sync1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_sync1_q <= 4'd0;
            f_sync2_q <= 4'd0;
        end else begin
            f_sync1_q <= f_sync1_d;
            f_sync2_q <= f_sync2_d;
        end
    end

    assign f_cmp = f_sync2_q;
`else
    assign f_cmp = f_in;
`endif

    // Golden nibble for the index currently under test.
    logic [3:0] exp_nib;
    logic       mismatch;

    assign exp_nib  = EXPECTED[{idx_q, 2'b00} +: 4];
    assign mismatch = (f_cmp != exp_nib);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            abcd_q     <= 4'd0;
            cnt_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= 4'd0;
            fail_cnt_q <= 5'd0;
            table_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            abcd_q     <= abcd_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
            fail_cnt_q <= fail_cnt_d;
            table_q    <= table_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_d = (idx_q == 4'd15) ? ST_FINISH : ST_SETTLE;
            end
            ST_FINISH: begin
                // start is deliberately ignored here. A held start re-arms
                // from IDLE one cycle later.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        idx_d      = idx_q;
        abcd_d     = abcd_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        fail_cnt_d = fail_cnt_q;
        table_d    = table_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d      = 4'd0;
                    abcd_d     = 4'd0;
                    cnt_d      = CNT_RELOAD;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    fail_idx_d = 4'd0;
                    fail_cnt_d = 5'd0;
                    table_d    = 64'd0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                table_d[{idx_q, 2'b00} +: 4] = f_cmp;
                if (mismatch) begin
                    fail_cnt_d = fail_cnt_q + 5'd1;
                    // The first mismatch is also the lowest index, because
                    // the sweep runs in ascending order.
                    if (fail_cnt_q == 5'd0) begin
                        fail_idx_d = idx_q;
                    end
                end
                if (idx_q == 4'd15) begin
                    // Results are registered on entry to FINISH, so done,
                    // busy and pass all change on the same edge.
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    pass_d = (fail_cnt_d == 5'd0);
                end else begin
                    idx_d  = idx_q + 4'd1;
                    abcd_d = idx_q + 4'd1;
                    cnt_d  = CNT_RELOAD;
                end
            end
            ST_FINISH: begin
                // done_d defaults to 0, which ends the one-cycle pulse.
            end
            default: begin
            end
        endcase
    end

    assign abcd      = abcd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_idx  = fail_idx_q;
    assign fail_cnt  = fail_cnt_q;
    assign table_out = table_q;

endmodule

// File: doc/pal_sweep_checker.md
# pal_sweep_checker

Self-test sequencer that sits directly upstream and downstream of a 4-input, 4-output combinational PAL. It drives the PAL's A/B/C/D inputs through all 16 input combinations, waits a programmable settle time per vector, captures the PAL's F1..F4 outputs into a 64-bit truth table, and compares each entry against a golden table. It reports pass/fail, the first failing index and the failure count, with a one-cycle done pulse.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles `abcd` is held before the sample cycle. Legal range 1..255; minimum 2 when `PAL_SWEEP_SYNC_EN` is defined.
- EXPECTED, default 64'hFEDCBA9876543210: golden table. Nibble i, bits [4*i+3:4*i], is the required {F4,F3,F2,F1} for input index i.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a sweep; accepted only in IDLE.
- abcd  out  4  {A,B,C,D} driven to the PAL; A is the MSB; registered.
- f_in  in  4  {F4,F3,F2,F1} returned from the PAL.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 when all 16 entries matched; valid from `done`, held until the next accepted start.
- fail_idx  out  4  lowest mismatching index; 0 when pass=1.
- fail_cnt  out  5  number of mismatching indices, 0..16.
- table_out  out  64  captured table, same nibble layout as EXPECTED.

## Operation
- States: IDLE, SETTLE, SAMPLE, FINISH.
- Reset values: state=IDLE, idx=0, abcd=0, busy=0, done=0, pass=0, fail_idx=0, fail_cnt=0, table_out=0, settle counter=0.
- IDLE: if start=1, the next edge does all of the following:
  - set idx=0 and abcd=0;
  - load the settle counter with SETTLE_CYCLES-1;
  - clear table_out, fail_cnt, fail_idx and pass;
  - set busy=1 and enter SETTLE.
- SETTLE: decrement the counter; when it is 0, go to SAMPLE.
- SAMPLE: the edge ending this cycle does all of the following:
  - write f_in to table_out nibble idx;
  - on mismatch with EXPECTED nibble idx: increment fail_cnt, and on the first mismatch latch fail_idx=idx;
  - if idx=15, go to FINISH; otherwise set idx=idx+1, abcd=idx+1, reload the counter, and go to SETTLE.
- FINISH: done=1 for this cycle only, busy=0, pass=(fail_cnt==0). Return to IDLE on the next edge.
- Comparison is an exact 4-bit equality; there is no masking.
- start is ignored outside IDLE, including during FINISH. Holding start high re-arms in IDLE, so a new sweep begins one cycle after done.
- abcd changes only on entry to SETTLE. It holds its last value (15) after a sweep until the next start.

## Timing
- Per vector: SETTLE_CYCLES + 1 cycles (SETTLE_CYCLES in SETTLE, 1 in SAMPLE).
- The f_in sample reflects an abcd value that has been stable for SETTLE_CYCLES+1 edges. The PAL's combinational path must settle within one cycle.
- Start accepted at edge 0:
  - busy is high from edge 0 to edge 16*(SETTLE_CYCLES+1).
  - done is high for one cycle, from edge 16*(SETTLE_CYCLES+1) to the next edge.
  - With the default SETTLE_CYCLES=2, done occupies the cycle after edge 48.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronous). No partial results are retained, and done does not pulse.

## Configuration
- `PAL_SWEEP_SYNC_EN` defined:
  - f_in passes through a two-flop synchronizer before compare and capture. This supports a PAL on a separate device or board.
  - The captured value is f_in as of two edges before the SAMPLE edge.
  - SETTLE_CYCLES must be at least 2; the design is elaborated with a parameter check that errors below 2.
  - Sweep length is unchanged.
- Undefined: f_in is sampled directly; SETTLE_CYCLES must be at least 1.

## Test plan
- Identity stub (f_in=abcd), defaults, start pulse at edge 0 -> done in the cycle after edge 48; pass=1, fail_cnt=0, fail_idx=0, table_out=64'hFEDCBA9876543210.
- Stub returns abcd except 4'h0 at index 5 -> pass=0, fail_idx=5, fail_cnt=1, table_out=64'hFEDCBA9876043210.
- Stub f_in=~abcd -> pass=0, fail_cnt=16, fail_idx=0, table_out=64'h0123456789ABCDEF.
- start pulsed at edges 0, 10 and 48 -> only one sweep runs, done pulses once, busy is continuous from edge 0 to edge 48. start held high -> second busy rises the cycle after done.
- rst_n low during SETTLE of idx=7, then released -> abcd=0, busy=0, table_out=0, no done pulse; the next start runs a full 16-vector sweep with identical results.
- `PAL_SWEEP_SYNC_EN` defined, SETTLE_CYCLES=2, identity stub -> pass=1, done at the same cycle as without the macro. SETTLE_CYCLES=1 -> elaboration error.
